mem_port_arbiter: RTL and testbench
===================================

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameter TIMEOUT, default 255: number of cycles the block waits for downstream ack before aborting; legal range 1..255.
REQ-002 sys_clk  in  1  single clock; all logic on rising edge.
REQ-003 sys_rst  in  1  reset, synchronous and active-high.
REQ-004 inst_stb_i  in  1  instruction-fetch request; held high until inst_ack_o.
REQ-005 inst_addr_i  in  11  fetch word address.
REQ-006 inst_ack_o  out  1  one-cycle completion pulse to fetch requester.
REQ-007 inst_data_o  out  16  fetch read data, valid while inst_ack_o=1.
REQ-008 data_stb_i  in  1  load/store request; held high until data_ack_o.
REQ-009 data_we_i  in  1  1=write, 0=read.
REQ-010 data_addr_i  in  16  data word address.
REQ-011 data_wdata_i  in  16  write data.
REQ-012 data_ack_o  out  1  one-cycle completion pulse to data requester.
REQ-013 data_rdata_o  out  16  read data, valid while data_ack_o=1.
REQ-014 err_o  out  1  high with an ack pulse when that transaction timed out.
REQ-015 mem_stb_o / mem_we_o  out  1/1  downstream request and direction.
REQ-016 mem_addr_o / mem_wdata_o  out  16/16  downstream address and write data.
REQ-017 mem_ack_i / mem_rdata_i  in  1/16  downstream completion and read data.

Function
REQ-018 States: IDLE, BUSY_I, BUSY_D, DONE; one outstanding downstream transaction at a time.
REQ-019 IDLE, only inst_stb_i=1 -> BUSY_I; only data_stb_i=1 -> BUSY_D; neither -> stay IDLE.
REQ-020 IDLE, both high: round-robin; grant goes to the requester NOT served last; last_grant register updates on every grant.
REQ-021 On grant edge, latch address (inst_addr_i zero-extended to 16 bits), we (0 for fetch), wdata; mem_stb_o=1 from the next cycle with latched values, stable until end of transaction.
REQ-022 BUSY_x: mem_stb_o held; when mem_ack_i sampled 1, capture mem_rdata_i, drop mem_stb_o, go to DONE.
REQ-023 DONE: exactly one cycle; ack_o of the granted requester =1 with captured data; other requester's ack stays 0; then IDLE.
REQ-024 Minimum latency: stb high at edge N, mem_ack_i at edge N+1 -> requester ack at cycle N+2; back-to-back transactions separated by one IDLE cycle.
REQ-025 Timeout counter (8 bits) cleared on grant, increments each BUSY cycle without mem_ack_i; at count==TIMEOUT: drop mem_stb_o, go to DONE with err_o=1 and read data 16'h0000.
REQ-026 mem_ack_i in IDLE or DONE ignored; late ack after timeout does not produce a second requester ack.
REQ-027 Requester dropping stb mid-transaction does not abort; transaction completes, ack still pulsed.
REQ-028 Write transactions return read data 16'h0000 with ack.
REQ-029 inst_data_o/data_rdata_o hold last value outside ack; err_o=0 except during a timed-out ack.

Reset
REQ-030 sys_rst=1 sampled at an edge: state=IDLE, all outputs 0, counter 0, last_grant=inst (data wins first tie).
REQ-031 Reset mid-transaction abandons it silently: no ack issued; mem_stb_o low on the cycle after the reset edge.

Structure
REQ-032 Shared package mem_arb_pkg holds state encodings, requester IDs (ID_INST, ID_DATA) and TIMEOUT default.
REQ-033 One sub-module, rr_arb2 (2-way round-robin grant + last_grant register), is natural; FSM, latches and timer stay in top.

Verification
REQ-034 Fetch only: inst_addr_i=11'h123, mem_ack_i one cycle after mem_stb_o, mem_rdata_i=16'hBEEF -> mem_addr_o=16'h0123, mem_we_o=0, inst_ack_o one cycle with inst_data_o=16'hBEEF, data_ack_o=0.
REQ-035 Store: data_addr_i=16'h0400, wdata 16'h1234, we=1 -> mem_we_o=1, mem_wdata_o=16'h1234, single data_ack_o pulse, err_o=0.
REQ-036 Both stb high simultaneously after reset, held -> order data, inst, data, inst over four transactions.
REQ-037 TIMEOUT=4, mem_ack_i never asserted -> mem_stb_o high 4 cycles, then ack with err_o=1, data 16'h0000; ack injected afterwards ignored.
REQ-038 sys_rst asserted while BUSY_D -> no data_ack_o, mem_stb_o=0 next cycle, next tie grants data.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-requester memory port arbiter.
// Holds FSM state encodings, requester IDs and the latched downstream request.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_BUSY_I = 2'd1,
        ST_BUSY_D = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    localparam logic ID_INST = 1'b0;
    localparam logic ID_DATA = 1'b1;

    localparam int TIMEOUT_DEFAULT = 255;

    typedef struct packed {
        logic        we;
        logic [15:0] addr;
        logic [15:0] wdata;
    } mem_req_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin grant; a tie goes to the requester not served last.
// Latency: combinational grant, last_grant updates on the granting edge.
// Backpressure: grants only while gnt_en is high; requests are level-held upstream.
module rr_arb2
    import mem_arb_pkg::*;
(
    input  logic sys_clk,
    input  logic sys_rst,
    input  logic req_inst,
    input  logic req_data,
    input  logic gnt_en,
    output logic gnt_vld,
    output logic gnt_id
);

    logic last_grant_q;

    assign gnt_vld = req_inst | req_data;
    assign gnt_id  = (req_data && (!req_inst || last_grant_q == ID_INST)) ? ID_DATA : ID_INST;

    // Reset to inst so that the first tie after reset goes to data.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            last_grant_q <= ID_INST;
        end else if (gnt_en && gnt_vld) begin
            last_grant_q <= gnt_id;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates fetch and load/store requesters onto one downstream memory port.
// Latency: stb at edge N, mem ack at N+1 -> requester ack in cycle N+2; one idle cycle between transactions.
// Backpressure: one outstanding transaction; requesters wait for ack, downstream stalls bounded by TIMEOUT.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic        sys_clk,
    input  logic        sys_rst,
    input  logic        inst_stb_i,
    input  logic [10:0] inst_addr_i,
    output logic        inst_ack_o,
    output logic [15:0] inst_data_o,
    input  logic        data_stb_i,
    input  logic        data_we_i,
    input  logic [15:0] data_addr_i,
    input  logic [15:0] data_wdata_i,
    output logic        data_ack_o,
    output logic [15:0] data_rdata_o,
    output logic        err_o,
    output logic        mem_stb_o,
    output logic        mem_we_o,
    output logic [15:0] mem_addr_o,
    output logic [15:0] mem_wdata_o,
    input  logic        mem_ack_i,
    input  logic [15:0] mem_rdata_i
);

    localparam logic [7:0] TMR_LAST = 8'(TIMEOUT - 1);

    state_t      state_q, state_d;
    mem_req_t    req_q;
    logic        owner_q;
    logic        err_q;
    logic [7:0]  tmr_q;
    logic [15:0] inst_data_q, data_rdata_q;
    logic        gnt_vld, gnt_id;
    logic        busy, ack_hit, tmo_hit, grant;
    logic [15:0] rd_c;

    rr_arb2 u_rr_arb2 (
        .sys_clk  (sys_clk),
        .sys_rst  (sys_rst),
        .req_inst (inst_stb_i),
        .req_data (data_stb_i),
        .gnt_en   (state_q == ST_IDLE),
        .gnt_vld  (gnt_vld),
        .gnt_id   (gnt_id)
    );

    assign busy    = (state_q == ST_BUSY_I) || (state_q == ST_BUSY_D);
    assign grant   = (state_q == ST_IDLE) && gnt_vld;
    assign ack_hit = busy && mem_ack_i;
    // Timeout fires on the cycle whose increment would reach TIMEOUT, so stb stays up exactly TIMEOUT cycles.
    assign tmo_hit = busy && !mem_ack_i && (tmr_q == TMR_LAST);
    assign rd_c    = (tmo_hit || req_q.we) ? 16'h0000 : mem_rdata_i;

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (gnt_vld) begin
                    state_d = (gnt_id == ID_DATA) ? ST_BUSY_D : ST_BUSY_I;
                end
            end
            ST_BUSY_I, ST_BUSY_D: begin
                if (ack_hit || tmo_hit) begin
                    state_d = ST_DONE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        mem_stb_o  = busy;
        inst_ack_o = (state_q == ST_DONE) && (owner_q == ID_INST);
        data_ack_o = (state_q == ST_DONE) && (owner_q == ID_DATA);
        err_o      = (state_q == ST_DONE) && err_q;
    end

    assign mem_we_o     = req_q.we;
    assign mem_addr_o   = req_q.addr;
    assign mem_wdata_o  = req_q.wdata;
    assign inst_data_o  = inst_data_q;
    assign data_rdata_o = data_rdata_q;

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            req_q        <= '0;
            owner_q      <= ID_INST;
            err_q        <= 1'b0;
            tmr_q        <= 8'd0;
            inst_data_q  <= 16'h0000;
            data_rdata_q <= 16'h0000;
        end else begin
            if (grant) begin
                owner_q <= gnt_id;
                tmr_q   <= 8'd0;
                if (gnt_id == ID_DATA) begin
                    req_q <= '{we: data_we_i, addr: data_addr_i, wdata: data_wdata_i};
                end else begin
                    req_q <= '{we: 1'b0, addr: {5'b0, inst_addr_i}, wdata: 16'h0000};
                end
            end else if (busy && !mem_ack_i) begin
                tmr_q <= tmr_q + 8'd1;
            end
            if (ack_hit || tmo_hit) begin
                err_q <= tmo_hit;
                if (owner_q == ID_INST) begin
                    inst_data_q <= rd_c;
                end else begin
                    data_rdata_q <= rd_c;
                end
            end
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter built with TIMEOUT=4.
module tb_mem_port_arbiter;

    logic        sys_clk = 1'b0;
    logic        sys_rst;
    logic        inst_stb_i;
    logic [10:0] inst_addr_i;
    logic        inst_ack_o;
    logic [15:0] inst_data_o;
    logic        data_stb_i;
    logic        data_we_i;
    logic [15:0] data_addr_i;
    logic [15:0] data_wdata_i;
    logic        data_ack_o;
    logic [15:0] data_rdata_o;
    logic        err_o;
    logic        mem_stb_o;
    logic        mem_we_o;
    logic [15:0] mem_addr_o;
    logic [15:0] mem_wdata_o;
    logic        mem_ack_i;
    logic [15:0] mem_rdata_i;

    int vectors = 0;
    int miscompares = 0;

    always #5 sys_clk = ~sys_clk;

    mem_port_arbiter #(.TIMEOUT(4)) dut (
        .sys_clk      (sys_clk),
        .sys_rst      (sys_rst),
        .inst_stb_i   (inst_stb_i),
        .inst_addr_i  (inst_addr_i),
        .inst_ack_o   (inst_ack_o),
        .inst_data_o  (inst_data_o),
        .data_stb_i   (data_stb_i),
        .data_we_i    (data_we_i),
        .data_addr_i  (data_addr_i),
        .data_wdata_i (data_wdata_i),
        .data_ack_o   (data_ack_o),
        .data_rdata_o (data_rdata_o),
        .err_o        (err_o),
        .mem_stb_o    (mem_stb_o),
        .mem_we_o     (mem_we_o),
        .mem_addr_o   (mem_addr_o),
        .mem_wdata_o  (mem_wdata_o),
        .mem_ack_i    (mem_ack_i),
        .mem_rdata_i  (mem_rdata_i)
    );

    task automatic step();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        sys_rst = 1'b1;
        inst_stb_i = 1'b0; inst_addr_i = '0;
        data_stb_i = 1'b0; data_we_i = 1'b0; data_addr_i = '0; data_wdata_i = '0;
        mem_ack_i = 1'b0; mem_rdata_i = '0;
        step(); step();
        chk("rst_mem_stb", 16'(mem_stb_o), 16'h0);
        chk("rst_acks", {14'h0, inst_ack_o, data_ack_o}, 16'h0);
        chk("rst_err", 16'(err_o), 16'h0);
        chk("rst_mem_addr", mem_addr_o, 16'h0000);
        chk("rst_inst_data", inst_data_o, 16'h0000);
        sys_rst = 1'b0;

        // Fetch with one-cycle downstream ack.
        inst_stb_i = 1'b1; inst_addr_i = 11'h123;
        step();
        chk("fetch_mem_stb", 16'(mem_stb_o), 16'h1);
        chk("fetch_mem_addr", mem_addr_o, 16'h0123);
        chk("fetch_mem_we", 16'(mem_we_o), 16'h0);
        mem_ack_i = 1'b1; mem_rdata_i = 16'hBEEF;
        step();
        chk("fetch_inst_ack", 16'(inst_ack_o), 16'h1);
        chk("fetch_inst_data", inst_data_o, 16'hBEEF);
        chk("fetch_data_ack", 16'(data_ack_o), 16'h0);
        chk("fetch_mem_stb_done", 16'(mem_stb_o), 16'h0);
        inst_stb_i = 1'b0; mem_ack_i = 1'b0; mem_rdata_i = 16'h0;
        step();
        chk("fetch_ack_pulse", 16'(inst_ack_o), 16'h0);
        chk("fetch_data_hold", inst_data_o, 16'hBEEF);

        // Store; requester drops stb after the grant, ack arrives after a stall cycle.
        data_stb_i = 1'b1; data_we_i = 1'b1; data_addr_i = 16'h0400; data_wdata_i = 16'h1234;
        step();
        chk("store_mem_we", 16'(mem_we_o), 16'h1);
        chk("store_mem_wdata", mem_wdata_o, 16'h1234);
        chk("store_mem_addr", mem_addr_o, 16'h0400);
        data_stb_i = 1'b0; data_addr_i = 16'hFFFF; data_wdata_i = 16'hFFFF;
        step();
        chk("store_stall_stb", 16'(mem_stb_o), 16'h1);
        chk("store_stall_addr", mem_addr_o, 16'h0400);
        chk("store_stall_ack", 16'(data_ack_o), 16'h0);
        mem_ack_i = 1'b1; mem_rdata_i = 16'hFFFF;
        step();
        chk("store_ack", 16'(data_ack_o), 16'h1);
        chk("store_rdata_zero", data_rdata_o, 16'h0000);
        chk("store_err", 16'(err_o), 16'h0);
        mem_ack_i = 1'b0;
        step();
        chk("store_single_ack", 16'(data_ack_o), 16'h0);

        // Round-robin with both requesters held high after reset.
        sys_rst = 1'b1;
        step();
        sys_rst = 1'b0;
        inst_stb_i = 1'b1; inst_addr_i = 11'h055;
        data_stb_i = 1'b1; data_we_i = 1'b0; data_addr_i = 16'hA0A0;
        mem_ack_i = 1'b1; mem_rdata_i = 16'h5A5A;
        for (int k = 0; k < 4; k++) begin
            logic exp_d;
            exp_d = (k % 2 == 0);
            step();
            chk($sformatf("rr%0d_addr", k), mem_addr_o, exp_d ? 16'hA0A0 : 16'h0055);
            step();
            chk($sformatf("rr%0d_data_ack", k), 16'(data_ack_o), 16'(exp_d));
            chk($sformatf("rr%0d_inst_ack", k), 16'(inst_ack_o), 16'(!exp_d));
            step();
        end
        inst_stb_i = 1'b0; data_stb_i = 1'b0; mem_ack_i = 1'b0;
        step();

        // Timeout: downstream never acks.
        inst_stb_i = 1'b1; inst_addr_i = 11'h7FF; mem_rdata_i = 16'hDEAD;
        step();
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("tmo_stb%0d", k), 16'(mem_stb_o), 16'h1);
            chk($sformatf("tmo_noack%0d", k), 16'(inst_ack_o), 16'h0);
            step();
        end
        chk("tmo_stb_dropped", 16'(mem_stb_o), 16'h0);
        chk("tmo_ack", 16'(inst_ack_o), 16'h1);
        chk("tmo_err", 16'(err_o), 16'h1);
        chk("tmo_data", inst_data_o, 16'h0000);
        inst_stb_i = 1'b0; mem_ack_i = 1'b1;
        step();
        chk("late_ack_ignored", 16'(inst_ack_o), 16'h0);
        chk("late_err_clear", 16'(err_o), 16'h0);
        step();
        chk("late_ack_ignored2", {14'h0, inst_ack_o, data_ack_o}, 16'h0);
        chk("late_ack_no_stb", 16'(mem_stb_o), 16'h0);
        mem_ack_i = 1'b0;

        // Reset while BUSY_D abandons the transaction and restores the tie preference.
        data_stb_i = 1'b1; data_we_i = 1'b0; data_addr_i = 16'h0777;
        step();
        chk("rstmid_busy_addr", mem_addr_o, 16'h0777);
        sys_rst = 1'b1; mem_ack_i = 1'b1; mem_rdata_i = 16'h1111;
        step();
        chk("rstmid_stb", 16'(mem_stb_o), 16'h0);
        chk("rstmid_no_ack", 16'(data_ack_o), 16'h0);
        sys_rst = 1'b0; data_stb_i = 1'b0; mem_ack_i = 1'b0;
        step();
        chk("rstmid_no_ack_after", 16'(data_ack_o), 16'h0);
        inst_stb_i = 1'b1; inst_addr_i = 11'h001;
        data_stb_i = 1'b1; data_addr_i = 16'h0888;
        step();
        chk("rstmid_tie_addr", mem_addr_o, 16'h0888);
        mem_ack_i = 1'b1; mem_rdata_i = 16'h2468;
        step();
        chk("rstmid_tie_data_ack", 16'(data_ack_o), 16'h1);
        chk("rstmid_tie_inst_ack", 16'(inst_ack_o), 16'h0);
        chk("rstmid_tie_rdata", data_rdata_o, 16'h2468);
        inst_stb_i = 1'b0; data_stb_i = 1'b0; mem_ack_i = 1'b0;
        step();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
